// File: rtl/tmds_decoder.sv
// Receive side of one TMDS lane. It finds the 10-bit word boundary by slipping the
// alignment until control tokens repeat, then decodes each word as pixel data or a control value.
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_pixel,
  input  logic       rst_sync_n,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl,
  output logic       data_en,
  output logic       locked,
  output logic       lock_lost,
  output logic [3:0] slip_offset
);

  localparam int TIMER_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX);
  localparam int CNT_W     = $clog2(LOCK_COUNT + 1);

  localparam logic [TIMER_W-1:0] SEARCH_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOSS_LAST   = TIMER_W'(LOSS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL    = CNT_W'(LOCK_COUNT);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         cur_q, cur_d;
  logic [9:0]         prev_q, prev_d;
  logic [3:0]         offset_q, offset_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic [7:0]         data_out_q, data_out_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               data_en_q, data_en_d;
  logic               lock_lost_q, lock_lost_d;

  logic [9:0] aligned;
  logic       is_token;
  logic [1:0] tok_val;
  logic [3:0] offset_next;

  // The offset picks a 10-bit window out of {cur, prev}; bit 0 of prev is the oldest serial bit.
  assign aligned     = 10'({cur_q, prev_q} >> offset_q);
  assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  function automatic logic [7:0] decode_word(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] b;
    d    = w[9] ? ~w[7:0] : w[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      b[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return b;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_token = 1'b1;
    tok_val  = 2'b00;
    case (aligned)
      TOK_00:  tok_val = 2'b00;
      TOK_01:  tok_val = 2'b01;
      TOK_10:  tok_val = 2'b10;
      TOK_11:  tok_val = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  always_comb begin
    cur_d       = tmds_in;
    prev_d      = cur_q;
    state_d     = state_q;
    offset_d    = offset_q;
    timer_d     = timer_q + TIMER_W'(1);
    data_out_d  = 8'h00;
    data_en_d   = 1'b0;
    ctrl_d      = ctrl_q;
    lock_lost_d = 1'b0;
    if (!is_token) begin
      tok_cnt_d = '0;
    end else if (tok_cnt_q == CNT_FULL) begin
      tok_cnt_d = tok_cnt_q;
    end else begin
      tok_cnt_d = tok_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_SEARCH: begin
        // Lock takes priority over a slip due in the same cycle.
        if (tok_cnt_q == CNT_FULL) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else if (timer_q == SEARCH_LAST) begin
          offset_d  = offset_next;
          timer_d   = '0;
          tok_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (is_token) begin
          timer_d = '0;
          ctrl_d  = tok_val;
        end else if (timer_q == LOSS_LAST) begin
          state_d     = ST_SEARCH;
          offset_d    = offset_next;
          timer_d     = '0;
          tok_cnt_d   = '0;
          lock_lost_d = 1'b1;
        end else begin
          data_en_d  = 1'b1;
          data_out_d = decode_word(aligned);
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
  always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ST_SEARCH;
      cur_q       <= '0;
      prev_q      <= '0;
      offset_q    <= '0;
      timer_q     <= '0;
      tok_cnt_q   <= '0;
      data_out_q  <= '0;
      ctrl_q      <= '0;
      data_en_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      offset_q    <= offset_d;
      timer_q     <= timer_d;
      tok_cnt_q   <= tok_cnt_d;
      data_out_q  <= data_out_d;
      ctrl_q      <= ctrl_d;
      data_en_q   <= data_en_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign data_out    = data_out_q;
  assign ctrl        = ctrl_q;
  assign data_en     = data_en_q;
  assign locked      = (state_q == ST_LOCKED);
  assign lock_lost   = lock_lost_q;
  assign slip_offset = offset_q;

endmodule
